// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, 8 serializer data bits, optional parity, stop.
// Define UART_TX_PARITY_EN to build in the parity bit (sense set by PAR_TYP: 0 even, 1 odd).
module uart_tx_ctrl #(
    parameter int PAR_TYP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic [7:0] p_data,
    output logic       data_ready,
    output logic       ser_en,
    output logic [7:0] ser_word,
    input  logic       ser_data,
    input  logic       ser_done,
    output logic       tx_out,
    output logic       busy,
    output logic       tx_done
);

    // state  | meaning
    // IDLE   | line idle high, waiting for a byte
    // START  | start bit (0), one cycle
    // DATA   | eight data bits from the serializer, LSB first
    // PARITY | parity bit, one cycle (parity build only)
    // STOP   | stop bit (1), may accept the next byte back-to-back
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] ser_word_q, ser_word_d;
    logic       last_q, last_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

`ifdef UART_TX_PARITY_EN
    logic par_bit;
    assign par_bit = (^ser_word_q) ^ (PAR_TYP != 0);
`else
    // PAR_TYP has no effect without the parity build.
    if (PAR_TYP != 0) begin : g_par_typ_ignored
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ser_word_q <= 8'h00;
            last_q     <= 1'b0;
            bit_cnt_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            ser_word_q <= ser_word_d;
            last_q     <= last_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ser_word_d = ser_word_q;
        last_d     = 1'b0;
        bit_cnt_d  = 3'd0;
        data_ready = 1'b0;
        ser_en     = 1'b0;
        tx_out     = 1'b1;
        busy       = 1'b1;
        tx_done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                data_ready = 1'b1;
                busy       = 1'b0;
                if (data_valid) begin
                    ser_word_d = p_data;
                    state_d    = S_START;
                end
            end
            S_START: begin
                tx_out  = 1'b0;
                state_d = S_DATA;
            end
            S_DATA: begin
                ser_en    = 1'b1;
                tx_out    = ser_data;
                last_d    = ser_done;
                bit_cnt_d = bit_cnt_q + 3'd1;
                // The local count bounds the frame even if ser_done never arrives.
                if (last_q || (bit_cnt_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_out  = par_bit;
                state_d = S_STOP;
            end
`endif
            S_STOP: begin
                data_ready = 1'b1;
                tx_done    = 1'b1;
                if (data_valid) begin
                    ser_word_d = p_data;
                    state_d    = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ser_word = ser_word_q;

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter PAR_TYP, default 0, parity sense: 0 = even, 1 = odd; used only when UART_TX_PARITY_EN is defined.
REQ-002 SHALL have port clk, input, 1, bit-rate clock; one line bit per cycle.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port data_valid, input, 1, the requester offers a byte on p_data.
REQ-005 SHALL have port p_data, input, 8, byte to transmit; sampled only on acceptance.
REQ-006 SHALL have port data_ready, output, 1, the controller can accept a byte this cycle.
REQ-007 SHALL have port ser_en, output, 1, enable to the serializer; serializer counter advances while high and clears while low.
REQ-008 SHALL have port ser_word, output, 8, latched byte driven to the serializer data input.
REQ-009 SHALL have port ser_data, input, 1, current serializer bit, LSB first.
REQ-010 SHALL have port ser_done, input, 1, serializer strobe, high in the 7th data cycle (counter = 6).
REQ-011 SHALL have port tx_out, output, 1, UART line, idle high.
REQ-012 SHALL have port busy, output, 1, a frame is in progress.
REQ-013 SHALL have port tx_done, output, 1, one-cycle pulse in the final stop-bit cycle.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 SHALL drive data_ready high in IDLE and STOP and low in every other state.
REQ-016 SHALL accept a byte at a rising edge where data_valid and data_ready are both high: latch p_data into ser_word and go to START.
REQ-017 SHALL ignore data_valid and p_data changes while data_ready is low; no byte is lost or queued.
REQ-018 SHALL drive tx_out combinationally: 1 in IDLE, 0 in START, ser_data in DATA, the parity bit in PARITY, 1 in STOP.
REQ-019 SHALL hold START for exactly 1 cycle, then go to DATA.
REQ-020 SHALL drive ser_en high only in DATA and keep DATA for exactly 8 cycles; the serializer counter is 0 in the first DATA cycle.
REQ-021 SHALL register ser_done into last_q, and leave DATA at the edge where last_q = 1, with bit 7 on the line in that cycle.
REQ-022 SHALL exit DATA to PARITY when the macro is defined and to STOP otherwise; PARITY lasts 1 cycle, then goes to STOP.
REQ-023 SHALL hold STOP for 1 cycle with tx_done = 1; then go to START if a byte is accepted that cycle (back-to-back, no idle gap), else to IDLE.
REQ-024 SHALL drive busy high in every state except IDLE.
REQ-025 SHALL, if ser_done is still low after 8 DATA cycles (protocol fault), still exit DATA on the 8th cycle using its own internal 3-bit bit counter.

Reset
REQ-026 SHALL, on rst at any time including mid-frame, next cycle give: state IDLE, tx_out = 1, busy = 0, ser_en = 0, tx_done = 0, data_ready = 1, ser_word = 0x00, last_q = 0, bit counter = 0.
REQ-027 SHALL give rst priority over a simultaneous data_valid; the byte is not accepted.

Configuration
REQ-028 SHALL, with UART_TX_PARITY_EN defined, insert PARITY, send XOR(ser_word) XOR PAR_TYP, and produce 11-bit frames.
REQ-029 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and logic, produce 10-bit frames, and ignore PAR_TYP.

Verification
REQ-030 Parity enabled, PAR_TYP = 0, send 0xA5 -> tx_out = 0,1,0,1,0,0,1,0,1,0,1; busy high for 11 cycles; tx_done pulses in cycle 11.
REQ-031 Parity enabled, send 0x01 -> parity bit = 1 with PAR_TYP = 0 and 0 with PAR_TYP = 1.
REQ-032 Macro undefined, data_valid held high with 0x00 then 0xFF -> 20 consecutive line bits 0,00000000,1,0,11111111,1 with no idle cycle; busy stays high throughout.
REQ-033 Pulse data_valid with 0x3C during DATA of frame 0x55 -> only 0x55 is sent; line stays 1 afterward.
REQ-034 Assert rst in the 4th DATA cycle -> next cycle tx_out = 1, busy = 0, ser_en = 0; the next accepted byte starts a clean frame.
REQ-035 Hold ser_done low -> DATA still lasts exactly 8 cycles and the frame completes.
